// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the multi-cycle integer divider.
//   DIV_WIDTH  - default operand/result width
//   DIV_CNT_W  - width of the iteration counter
//   div_state_e - divider control states
package div_pkg;
    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;
endpackage

// File: rtl/divider_step.sv
// divider_step: one combinational restoring shift-subtract iteration.
// Ports:
//   rem_in   - partial remainder before the step
//   dvd_bit  - next dividend bit shifted into the remainder
//   divisor  - divisor magnitude
//   rem_out  - partial remainder after the step
//   q_bit    - quotient bit produced by this step
module divider_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        shifted = {rem_in, dvd_bit};
        trial   = shifted - {1'b0, divisor};
        // A set top bit in the shifted remainder already exceeds any divisor;
        // otherwise the sign of the WIDTH+1 bit trial decides.
        q_bit   = shifted[WIDTH] | ~trial[WIDTH];
        rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end
endmodule

// File: rtl/divider.sv
// divider: multi-cycle restoring integer divider (DIV/DIVU), one quotient
// bit per clock behind a start/busy/done handshake.
// Configuration macro: DIVIDER_SIGNED_EN enables signed mode; without it
// every operation is unsigned and inpDivSigned is ignored.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   inpDivStart    - request, sampled only while idle
//   inpDivSigned   - 1 = signed, 0 = unsigned (sampled with start)
//   inpDivA/B      - dividend / divisor (sampled with start)
//   outDivQuot/Rem - quotient / remainder, held until the next completion
//   outDivBusy     - division in flight
//   outDivDone     - one-cycle completion pulse
//   outDivByZero   - divisor was zero, held with the results
module divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inpDivStart,
    input  logic             inpDivSigned,
    input  logic [WIDTH-1:0] inpDivA,
    input  logic [WIDTH-1:0] inpDivB,
    output logic [WIDTH-1:0] outDivQuot,
    output logic [WIDTH-1:0] outDivRem,
    output logic             outDivBusy,
    output logic             outDivDone,
    output logic             outDivByZero
);
    localparam int CNT_W = $clog2(WIDTH);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
    logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zero_q, zero_d;   // divisor of the in-flight op was zero
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;

`ifdef DIVIDER_SIGNED_EN
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] araw_q, araw_d;   // raw dividend, returned on divide by zero
    logic             a_neg, b_neg;

    assign a_neg = inpDivSigned & inpDivA[WIDTH-1];
    assign b_neg = inpDivSigned & inpDivB[WIDTH-1];
`else
    logic unused_signed;
    assign unused_signed = inpDivSigned;
`endif

    divider_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .dvd_bit (dvd_q[WIDTH-1]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_qbit)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
`ifdef DIVIDER_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        araw_d  = araw_q;
`endif
        case (state_q)
            IDLE: begin
                if (inpDivStart) begin
`ifdef DIVIDER_SIGNED_EN
                    dvd_d  = a_neg ? -inpDivA : inpDivA;
                    dvs_d  = b_neg ? -inpDivB : inpDivB;
                    qneg_d = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    araw_d = inpDivA;
`else
                    dvd_d  = inpDivA;
                    dvs_d  = inpDivB;
`endif
                    rem_d   = '0;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    zero_d  = (inpDivB == '0);
                    state_d = CALC;
                end
            end
            CALC: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[WIDTH-2:0], step_qbit};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) state_d = DONE;
            end
            DONE: begin
`ifdef DIVIDER_SIGNED_EN
                quot_d = qneg_q ? -dvd_q : dvd_q;
                remo_d = rneg_q ? -rem_q : rem_q;
                // Magnitude division by zero is sign-dependent; force the
                // architected result instead.
                if (zero_q) begin
                    quot_d = '1;
                    remo_d = araw_q;
                end
`else
                // Unsigned divide by zero yields all ones / dividend naturally.
                quot_d = dvd_q;
                remo_d = rem_q;
`endif
                dbz_d   = zero_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            remo_q  <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            araw_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
`ifdef DIVIDER_SIGNED_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            araw_q  <= araw_d;
`endif
        end
    end

    assign outDivQuot   = quot_q;
    assign outDivRem    = remo_q;
    assign outDivBusy   = (state_q != IDLE);
    assign outDivDone   = done_q;
    assign outDivByZero = dbz_q;
endmodule

// File: tb/tb_divider.sv
// tb_divider: randomized and directed self-checking bench for divider.
module tb_divider;
    logic        clk = 1'b0;
    logic        reset;
    logic        inpDivStart;
    logic        inpDivSigned;
    logic [31:0] inpDivA;
    logic [31:0] inpDivB;
    logic [31:0] outDivQuot;
    logic [31:0] outDivRem;
    logic        outDivBusy;
    logic        outDivDone;
    logic        outDivByZero;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    divider dut (
        .clk          (clk),
        .reset        (reset),
        .inpDivStart  (inpDivStart),
        .inpDivSigned (inpDivSigned),
        .inpDivA      (inpDivA),
        .inpDivB      (inpDivB),
        .outDivQuot   (outDivQuot),
        .outDivRem    (outDivRem),
        .outDivBusy   (outDivBusy),
        .outDivDone   (outDivDone),
        .outDivByZero (outDivByZero)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Architectural reference: plain integer arithmetic on the operands.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         output logic [31:0] q, output logic [31:0] r, output logic z);
        longint sa, sb, sq, sr;
        logic   s;
`ifdef DIVIDER_SIGNED_EN
        s = sgn;
`else
        s = 1'b0 & sgn;
`endif
        z = (b == 32'd0);
        if (z) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            q  = sq[31:0];
            r  = sr[31:0];
        end
    endtask

    // One division. inj_at >= 0 pulses a competing 9/3 start at that cycle;
    // tail = 1 checks that done drops and the unit idles the next cycle.
    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input int inj_at, input bit tail);
        logic [31:0] eq, er;
        logic        ez;
        int          n, busy_cnt;
        model(a, b, sgn, eq, er, ez);
        @(negedge clk);
        inpDivStart = 1'b1; inpDivA = a; inpDivB = b; inpDivSigned = sgn;
        @(posedge clk); #1;
        inpDivStart = 1'b0; inpDivA = $urandom; inpDivB = $urandom; inpDivSigned = $urandom;
        n = 0;
        busy_cnt = 0;
        while (!outDivDone && n < 100) begin
            if (outDivBusy) busy_cnt++;
            if (n == inj_at) begin
                inpDivStart = 1'b1; inpDivA = 32'd9; inpDivB = 32'd3; inpDivSigned = 1'b0;
            end else begin
                inpDivStart = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        inpDivStart = 1'b0;
        if (outDivBusy) busy_cnt++;
        chk({tag, "_latency"}, n, 33);
        chk({tag, "_busy"}, busy_cnt, 33);
        chk({tag, "_quot"}, outDivQuot, eq);
        chk({tag, "_rem"}, outDivRem, er);
        chk({tag, "_dbz"}, {31'd0, outDivByZero}, {31'd0, ez});
        if (tail) begin
            @(posedge clk); #1;
            chk({tag, "_done_pulse"}, {31'd0, outDivDone}, 32'd0);
            chk({tag, "_hold_quot"}, outDivQuot, eq);
        end
    endtask

    task automatic reset_mid();
        int seen;
        @(negedge clk);
        inpDivStart = 1'b1; inpDivA = 32'd1000; inpDivB = 32'd3; inpDivSigned = 1'b0;
        @(posedge clk); #1;
        inpDivStart = 1'b0;
        repeat (14) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_quot", outDivQuot, 32'd0);
        chk("rst_mid_rem", outDivRem, 32'd0);
        chk("rst_mid_busy", {31'd0, outDivBusy}, 32'd0);
        chk("rst_mid_dbz", {31'd0, outDivByZero}, 32'd0);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (outDivDone) seen++;
        end
        chk("rst_mid_nodone", seen, 0);
    endtask

    logic [31:0] corner [8] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000,
                                32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd7};

    initial begin
        logic [31:0] a, b;
        reset = 1'b1; inpDivStart = 1'b0; inpDivSigned = 1'b0;
        inpDivA = 32'd0; inpDivB = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_quot", outDivQuot, 32'd0);
        chk("reset_rem", outDivRem, 32'd0);
        chk("reset_busy", {31'd0, outDivBusy}, 32'd0);
        chk("reset_done", {31'd0, outDivDone}, 32'd0);
        chk("reset_dbz", {31'd0, outDivByZero}, 32'd0);
        reset = 1'b0;

        do_div("u8d2",   32'd8, 32'd2, 1'b0, -1, 1'b1);
        do_div("s-7d2",  32'hFFFF_FFF9, 32'd2, 1'b1, -1, 1'b1);
        do_div("s7d-2",  32'd7, 32'hFFFF_FFFE, 1'b1, -1, 1'b1);
        do_div("sovf",   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, 1'b1);
        do_div("umax",   32'hFFFF_FFFF, 32'd1, 1'b0, -1, 1'b1);
        do_div("s5d0",   32'd5, 32'd0, 1'b1, -1, 1'b1);
        do_div("u5d0",   32'd5, 32'd0, 1'b0, -1, 1'b1);
        do_div("s-5d0",  32'hFFFF_FFFB, 32'd0, 1'b1, -1, 1'b1);
        do_div("dbzclr", 32'd9, 32'd4, 1'b0, -1, 1'b1);
        do_div("ignore", 32'd100, 32'd7, 1'b0, 10, 1'b0);
        do_div("b2b",    32'd55, 32'd5, 1'b0, -1, 1'b1);
        reset_mid();
        do_div("postrst", 32'd1000, 32'd3, 1'b0, -1, 1'b1);

        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 7)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 7)] : $urandom;
            if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(1, 31);
            do_div($sformatf("rnd%0d", i), a, b, 1'($urandom), -1, (i % 4) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
